// File: rtl/memory_bus_arbiter.sv
// Shared coprocessor memory port arbiter.
// Requester 0 has fixed top priority; requesters 1..N-1 are served round-robin.
// Grants are non-preemptive. A full idle cycle always separates owners so the
// tri-state data bus can turn around. A sticky watchdog flags long bus holds.
module memory_bus_arbiter #(
  parameter int unsigned N_Requesters    = 5,
  parameter int unsigned memory_size_log = 10,
  parameter int unsigned Max_Hold        = 64
) (
  input  logic                                      i_Clock,
  input  logic                                      i_Reset,
  input  logic [N_Requesters-1:0]                   i_Request,
  input  logic [N_Requesters*memory_size_log-1:0]   i_Address,
  input  logic [N_Requesters-1:0]                   i_Write_Enable,
  output logic [N_Requesters-1:0]                   o_Grant,
  output logic                                      o_Grant_Valid,
  output logic [$clog2(N_Requesters)-1:0]           o_Owner,
  output logic [memory_size_log-1:0]                o_Memory_Address,
  output logic                                      o_Write_Enable,
  output logic                                      o_Hold_Overrun
);

  localparam int unsigned OW   = $clog2(N_Requesters);
  localparam int unsigned CW   = 16;
  localparam int unsigned RR_N = N_Requesters - 1;

  // Counter value at which a still-requesting owner has held for Max_Hold cycles
  localparam logic [CW-1:0] hold_limit = (Max_Hold == 0) ? '0 : CW'(Max_Hold - 1);
  localparam logic [N_Requesters-1:0] grant_one = N_Requesters'(1);

  typedef enum logic [0:0] {
    s_Idle  = 1'b0,
    s_Grant = 1'b1
  } state_t;

  state_t                  state, state_next;
  logic [N_Requesters-1:0] grant_next;
  logic [OW-1:0]           owner_next;
  logic [OW-1:0]           last, last_next;
  logic [CW-1:0]           count, count_next;
  logic                    overrun_next;

  logic [OW-1:0]           rr_winner;
  logic                    rr_found;
  int unsigned             rr_idx;

  logic [memory_size_log-1:0] addr_slot [N_Requesters];

  // Unpack the flattened address bus into one slot per requester
  for (genvar k = 0; k < N_Requesters; k++) begin : g_addr_slot
    assign addr_slot[k] = i_Address[k*memory_size_log +: memory_size_log];
  end

  // Round-robin search over 1..N-1, starting just after the last winner
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_idx    = 0;
    for (int unsigned i = 1; i < N_Requesters; i++) begin
      rr_idx = ((32'(last) - 1 + i) % RR_N) + 1;
      if (!rr_found && i_Request[OW'(rr_idx)]) begin
        rr_found  = 1'b1;
        rr_winner = OW'(rr_idx);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_next   = state;
    grant_next   = o_Grant;
    owner_next   = o_Owner;
    last_next    = last;
    count_next   = count;
    overrun_next = o_Hold_Overrun;
    case (state)
      s_Idle: begin
        if (i_Request[0]) begin
          grant_next = grant_one;
          owner_next = '0;
          count_next = '0;
          state_next = s_Grant;
        end else if (rr_found) begin
          grant_next = grant_one << rr_winner;
          owner_next = rr_winner;
          last_next  = rr_winner;
          count_next = '0;
          state_next = s_Grant;
        end
      end
      s_Grant: begin
        if (i_Request[o_Owner]) begin
          if (count != '1) begin
            count_next = count + CW'(1);
          end
          if ((Max_Hold != 0) && (count == hold_limit)) begin
            overrun_next = 1'b1;
          end
        end else begin
          grant_next = '0;
          owner_next = '0;
          state_next = s_Idle;
        end
      end
      default: begin
        grant_next = '0;
        owner_next = '0;
        state_next = s_Idle;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state          <= s_Idle;
      o_Grant        <= '0;
      o_Owner        <= '0;
      last           <= OW'(N_Requesters - 1);
      count          <= '0;
      o_Hold_Overrun <= 1'b0;
    end else begin
      state          <= state_next;
      o_Grant        <= grant_next;
      o_Owner        <= owner_next;
      last           <= last_next;
      count          <= count_next;
      o_Hold_Overrun <= overrun_next;
    end
  end

  // Owner mux onto the memory port, quiet when the bus is free
  assign o_Grant_Valid    = |o_Grant;
  assign o_Memory_Address = o_Grant_Valid ? addr_slot[o_Owner] : '0;
  assign o_Write_Enable   = o_Grant_Valid ? i_Write_Enable[o_Owner] : 1'b0;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter: stimulus queues expected owners,
// a negedge monitor pops them as new grants appear and checks mux outputs.
module tb_memory_bus_arbiter;

  localparam int unsigned N  = 5;
  localparam int unsigned AW = 10;
  localparam int unsigned OW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]  we;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [OW-1:0] owner;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          overrun;

  logic [AW-1:0] exp_addr [N] = '{10'h040, 10'h081, 10'h0C2, 10'h103, 10'h144};
  logic [N-1:0]  exp_we = 5'b10110;

  int checks = 0;
  int errors = 0;
  int exp_q [$];
  int cur_w = 0;
  logic [N-1:0] prev_grant = '0;
  logic [N-1:0] exp_g;

  memory_bus_arbiter #(
    .N_Requesters    (N),
    .memory_size_log (AW),
    .Max_Hold        (4)
  ) dut (
    .i_Clock          (clk),
    .i_Reset          (rst),
    .i_Request        (req),
    .i_Address        (addr),
    .i_Write_Enable   (we),
    .o_Grant          (grant),
    .o_Grant_Valid    (grant_valid),
    .o_Owner          (owner),
    .o_Memory_Address (mem_addr),
    .o_Write_Enable   (mem_we),
    .o_Hold_Overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // One transaction for an expected owner w: grant, one hold edge, release.
  task automatic transact(input int w, input bit raise0);
    exp_q.push_back(w);
    tick(2);
    req[w] = 1'b0;
    if (raise0) req[0] = 1'b1;
    tick(1);
    chk("turnaround_idle", 32'(grant), 32'h0);
    if (w != 0) req[w] = 1'b1;
  endtask

  // Monitor: one-hot, idle mux quiet, new grants match the scoreboard
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(grant) || (grant_valid !== (grant != '0))) begin
      errors++;
      $display("FAIL onehot: grant=%b valid=%b", grant, grant_valid);
    end
    if (grant == '0) begin
      checks++;
      if (mem_addr !== '0 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL idle_mux: addr=%h we=%b expected 0/0", mem_addr, mem_we);
      end
    end else begin
      if (prev_grant == '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: grant=%b owner=%0d expected none", grant, owner);
        end else begin
          cur_w = exp_q.pop_front();
        end
      end else if (grant !== prev_grant) begin
        checks++;
        errors++;
        $display("FAIL no_turnaround: grant=%b after %b expected idle cycle", grant, prev_grant);
      end
      exp_g = 5'b00001 << cur_w;
      checks++;
      if (grant !== exp_g || owner !== OW'(cur_w) ||
          mem_addr !== exp_addr[cur_w] || mem_we !== exp_we[cur_w]) begin
        errors++;
        $display("FAIL grant_mux: grant=%b owner=%0d addr=%h we=%b expected %b/%0d/%h/%b",
                 grant, owner, mem_addr, mem_we, exp_g, cur_w, exp_addr[cur_w], exp_we[cur_w]);
      end
    end
    prev_grant = grant;
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    addr = {exp_addr[4], exp_addr[3], exp_addr[2], exp_addr[1], exp_addr[0]};
    we   = exp_we;
    tick(2);
    rst = 1'b0;
    chk("reset_grant",   32'(grant),       32'h0);
    chk("reset_owner",   32'(owner),       32'h0);
    chk("reset_valid",   32'(grant_valid), 32'h0);
    chk("reset_overrun", 32'(overrun),     32'h0);
    chk("reset_addr",    32'(mem_addr),    32'h0);

    // Single requester 2 held three edges then dropped
    req = 5'b00100;
    exp_q.push_back(2);
    tick(1);
    chk("t1_grant", 32'(grant), 32'h04);
    chk("t1_owner", 32'(owner), 32'd2);
    tick(2);
    req = '0;
    tick(1);
    chk("t1_release", 32'(grant), 32'h0);
    chk("t1_addr_idle", 32'(mem_addr), 32'h0);

    // Round robin with requester 0 priority at arbitration edges
    do_reset();
    req = 5'b11111;
    transact(0, 1'b0);
    transact(1, 1'b0);
    transact(2, 1'b0);
    transact(3, 1'b0);
    transact(4, 1'b0);
    transact(1, 1'b1);
    transact(0, 1'b0);
    transact(2, 1'b0);
    req = '0;
    tick(1);

    // No preemption of owner 3 by requester 0
    req = 5'b01000;
    exp_q.push_back(3);
    exp_q.push_back(0);
    tick(1);
    req[0] = 1'b1;
    tick(1);
    chk("t3_no_preempt", 32'(grant), 32'h08);
    tick(1);
    req[3] = 1'b0;
    tick(1);
    chk("t3_idle_gap", 32'(grant), 32'h0);
    tick(1);
    chk("t3_grant0", 32'(grant), 32'h01);
    req = '0;
    tick(1);

    // Watchdog with Max_Hold=4
    do_reset();
    req = 5'b00010;
    exp_q.push_back(1);
    tick(1);
    chk("t4_ovr_start", 32'(overrun), 32'h0);
    tick(3);
    chk("t4_ovr_before", 32'(overrun), 32'h0);
    tick(1);
    chk("t4_ovr_set", 32'(overrun), 32'h1);
    chk("t4_still_granted", 32'(grant), 32'h02);
    tick(5);
    req = '0;
    tick(1);
    chk("t4_release", 32'(grant), 32'h0);
    chk("t4_ovr_sticky", 32'(overrun), 32'h1);
    tick(2);
    chk("t4_ovr_sticky2", 32'(overrun), 32'h1);
    do_reset();
    chk("t4_ovr_cleared", 32'(overrun), 32'h0);

    // Reset mid-grant restores pointer to start the search at 1
    req = 5'b00100;
    exp_q.push_back(2);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_grant", 32'(grant), 32'h0);
    chk("t5_owner", 32'(owner), 32'h0);
    chk("t5_we",    32'(mem_we), 32'h0);
    req = 5'b01010;
    exp_q.push_back(1);
    tick(1);
    chk("t5_rr_restart", 32'(owner), 32'd1);
    req = '0;
    tick(1);

    // Requester 4 drops for one edge while requester 2 waits
    req = 5'b10000;
    exp_q.push_back(4);
    tick(2);
    req = 5'b00100;
    tick(1);
    chk("t6_release4", 32'(grant), 32'h0);
    req = 5'b10100;
    exp_q.push_back(2);
    tick(1);
    chk("t6_grant2", 32'(owner), 32'd2);
    tick(1);
    req = 5'b10000;
    tick(1);
    exp_q.push_back(4);
    tick(1);
    chk("t6_grant4", 32'(owner), 32'd4);
    req = '0;
    tick(1);

    // Unsampled request pulse must never be granted
    #1 req = 5'b01000;
    #1 req = '0;
    tick(3);
    chk("t7_withdrawn", 32'(grant), 32'h0);

    tick(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
